// File: rtl/codec_if_pkg.sv
// Shared constants and types for the CS4272 serial interface.
package codec_if_pkg;

  localparam int CNT_W    = 10;
  localparam int SLOT_LEN = 32;

  localparam logic [CNT_W-1:0] CNT_VALID     = 10'h1FF;
  localparam logic [CNT_W-1:0] CNT_WRAP      = 10'h3FF;
  localparam logic [CNT_W-1:0] CNT_PRE_VALID = 10'h1FE;

  localparam logic [3:0] NIB_RISE = 4'b0111;
  localparam logic [3:0] NIB_FALL = 4'b1111;

  typedef enum logic [1:0] {
    SEQ_HOLD = 2'd0,
    SEQ_WARM = 2'd1,
    SEQ_RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/codec_if_clkgen.sv
// Timebase for the codec interface: free-running frame counter, registered
// codec clocks, and the bit/frame strobes that pace the datapath.
module codec_if_clkgen
  import codec_if_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             mclk,
  output logic             sclk,
  output logic             lrclk,
  output logic             rise,
  output logic             fall,
  output logic             frame
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mclk_q, mclk_d;
  logic             sclk_q, sclk_d;
  logic             lrclk_q, lrclk_d;

  // Clocks are taken from the next count so they line up with cnt_q.
  always_comb begin
    cnt_d   = cnt_q + 10'd1;
    mclk_d  = cnt_d[1];
    sclk_d  = cnt_d[3];
    lrclk_d = cnt_d[CNT_W-1];
  end

  // Counter and clock output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 10'd0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mclk_q  <= mclk_d;
      sclk_q  <= sclk_d;
      lrclk_q <= lrclk_d;
    end
  end

  assign cnt   = cnt_q;
  assign mclk  = mclk_q;
  assign sclk  = sclk_q;
  assign lrclk = lrclk_q;
  assign rise  = (cnt_q[3:0] == NIB_RISE);
  assign fall  = (cnt_q[3:0] == NIB_FALL);
  assign frame = (cnt_q == CNT_WRAP);

endmodule

// File: rtl/codec_i2s_if.sv
// CS4272 serial bridge: ADC deserialiser, DAC serialiser and codec reset sequencer.
// Define CODEC_IF_LOOPBACK_EN to transmit the received samples back to the DAC.
module codec_i2s_if
  import codec_if_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SD_out,
  input  logic [DATA_W-1:0] left_out,
  input  logic [DATA_W-1:0] right_out,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              RST_n,
  output logic              SD_in,
  output logic [DATA_W-1:0] left_in,
  output logic [DATA_W-1:0] right_in,
  output logic              VALID
);

  localparam int               BIT_W    = $clog2(SLOT_LEN);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  cnt_s;
  logic              rise_s, fall_s, frame_s;
  logic [BIT_W-1:0]  bit_pos_s;
  logic [DATA_W-1:0] rx_shift_s, tx_left_src_s, tx_right_src_s;
  logic              pre_valid_s;

  seq_state_e        seq_q, seq_d;
  logic              rst_codec_q, rst_codec_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] left_hold_q, left_hold_d, right_hold_q, right_hold_d;
  logic [DATA_W-1:0] left_in_q, left_in_d, right_in_q, right_in_d;
  logic [DATA_W-1:0] tx_q, tx_d, tx_buf_q, tx_buf_d;

  // rst_n is active high: it is the system reset, not the codec reset.
  codec_if_clkgen u_clkgen (
    .clk   (clk),
    .rst   (rst_n),
    .cnt   (cnt_s),
    .mclk  (MCLK),
    .sclk  (SCLK),
    .lrclk (LRCLK),
    .rise  (rise_s),
    .fall  (fall_s),
    .frame (frame_s)
  );

  assign bit_pos_s  = cnt_s[BIT_W+3:4];
  assign rx_shift_s = DATA_W'({rx_q, SD_out});
  // Outputs are loaded one clk early so VALID and the new words appear together.
  assign pre_valid_s = (cnt_s == CNT_PRE_VALID) && (seq_q == SEQ_RUN);

`ifdef CODEC_IF_LOOPBACK_EN
  assign tx_left_src_s  = left_hold_q;
  assign tx_right_src_s = right_hold_q;
`else
  assign tx_left_src_s  = left_out;
  assign tx_right_src_s = right_out;
`endif

  // Codec reset sequencer: hold one frame, then warm up one frame before VALID.
  always_comb begin
    seq_d = seq_q;
    case (seq_q)
      SEQ_HOLD: begin
        if (frame_s) seq_d = SEQ_WARM;
        else         seq_d = SEQ_HOLD;
      end
      SEQ_WARM: begin
        if (frame_s) seq_d = SEQ_RUN;
        else         seq_d = SEQ_WARM;
      end
      SEQ_RUN:  seq_d = SEQ_RUN;
      default:  seq_d = SEQ_HOLD;
    endcase
    rst_codec_d = (seq_d != SEQ_HOLD);
  end

  // Receive shifter, per-slot holding registers and the sample outputs.
  always_comb begin
    rx_d         = rx_q;
    left_hold_d  = left_hold_q;
    right_hold_d = right_hold_q;
    if (rise_s && (bit_pos_s <= LAST_BIT)) begin
      rx_d = rx_shift_s;
      if (bit_pos_s == LAST_BIT) begin
        if (cnt_s[CNT_W-1]) left_hold_d  = rx_shift_s;
        else                right_hold_d = rx_shift_s;
      end else begin
        left_hold_d = left_hold_q;
      end
    end else begin
      rx_d = rx_q;
    end

    valid_d = pre_valid_s;
    if (pre_valid_s) begin
      left_in_d  = left_hold_q;
      right_in_d = right_hold_q;
    end else begin
      left_in_d  = left_in_q;
      right_in_d = right_in_q;
    end
  end

  // Transmit shifter: left loads at the end of the right slot, right half a frame later.
  always_comb begin
    tx_d     = tx_q;
    tx_buf_d = tx_buf_q;
    if (cnt_s == CNT_VALID) begin
      tx_d     = tx_left_src_s;
      tx_buf_d = tx_right_src_s;
    end else if (cnt_s == CNT_WRAP) begin
      tx_d = tx_buf_q;
    end else if (fall_s) begin
      tx_d = tx_q << 1'b1;
    end else begin
      tx_d = tx_q;
    end
  end

  // Datapath and sequencer state.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      seq_q        <= SEQ_HOLD;
      rst_codec_q  <= 1'b0;
      valid_q      <= 1'b0;
      rx_q         <= '0;
      left_hold_q  <= '0;
      right_hold_q <= '0;
      left_in_q    <= '0;
      right_in_q   <= '0;
      tx_q         <= '0;
      tx_buf_q     <= '0;
    end else begin
      seq_q        <= seq_d;
      rst_codec_q  <= rst_codec_d;
      valid_q      <= valid_d;
      rx_q         <= rx_d;
      left_hold_q  <= left_hold_d;
      right_hold_q <= right_hold_d;
      left_in_q    <= left_in_d;
      right_in_q   <= right_in_d;
      tx_q         <= tx_d;
      tx_buf_q     <= tx_buf_d;
    end
  end

  assign RST_n    = rst_codec_q;
  assign VALID    = valid_q;
  assign SD_in    = tx_q[DATA_W-1];
  assign left_in  = left_in_q;
  assign right_in = right_in_q;

endmodule

// File: tb/tb_codec_i2s_if.sv
// Directed bench for codec_i2s_if with a bit-level CS4272 model on the serial pins.
module tb_codec_i2s_if;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              SD_out;
  logic [DATA_W-1:0] left_out, right_out;
  logic              MCLK, SCLK, LRCLK, RST_n, SD_in, VALID;
  logic [DATA_W-1:0] left_in, right_in;

  int errors = 0;
  int checks = 0;
  int tb_cyc = 0;

  logic [15:0] adc_l = 16'h0000;
  logic [15:0] adc_r = 16'h0000;
  logic [15:0] dec_sh = 16'h0000;
  logic [15:0] aout_lft = 16'h0000;
  logic [15:0] aout_rht = 16'h0000;
  int lft_n = 0;
  int rht_n = 0;
  int unused_ones = 0;

  codec_i2s_if #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SD_out    (SD_out),
    .left_out  (left_out),
    .right_out (right_out),
    .MCLK      (MCLK),
    .SCLK      (SCLK),
    .LRCLK     (LRCLK),
    .RST_n     (RST_n),
    .SD_in     (SD_in),
    .left_in   (left_in),
    .right_in  (right_in),
    .VALID     (VALID)
  );

  always #5 clk = ~clk;

  // Bench timebase: clocks since reset release.
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  // Codec model: drives ADC bits MSB first per slot, decodes DAC bits on SCLK rise.
  always @(negedge clk) begin : codec_model
    logic [9:0]  c;
    logic [4:0]  idx;
    logic [15:0] w;
    c   = tb_cyc[9:0];
    idx = c[8:4];
    w   = c[9] ? adc_l : adc_r;
    SD_out = (idx < 5'd16) ? w[4'd15 - idx[3:0]] : 1'b0;
    if (c[3:0] == 4'd8) begin
      if (idx < 5'd16) begin
        dec_sh = {dec_sh[14:0], SD_in};
        if (idx == 5'd15) begin
          if (c[9]) begin aout_lft = dec_sh; lft_n++; end
          else begin aout_rht = dec_sh; rht_n++; end
        end
      end else if (SD_in) begin
        unused_ones++;
      end
    end
  end

  task automatic test_reset();
    rst_n     = 1'b1;
    left_out  = 16'h8001;
    right_out = 16'h7FFE;
    adc_l     = 16'h1234;
    adc_r     = 16'hBEEF;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (MCLK !== 1'b0)      begin errors++; $display("FAIL reset_mclk: got %b want 0", MCLK); end
    checks++; if (SCLK !== 1'b0)      begin errors++; $display("FAIL reset_sclk: got %b want 0", SCLK); end
    checks++; if (LRCLK !== 1'b0)     begin errors++; $display("FAIL reset_lrclk: got %b want 0", LRCLK); end
    checks++; if (RST_n !== 1'b0)     begin errors++; $display("FAIL reset_rst_n: got %b want 0", RST_n); end
    checks++; if (SD_in !== 1'b0)     begin errors++; $display("FAIL reset_sd_in: got %b want 0", SD_in); end
    checks++; if (VALID !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b want 0", VALID); end
    checks++; if (left_in !== 16'h0)  begin errors++; $display("FAIL reset_left_in: got %h want 0000", left_in); end
    checks++; if (right_in !== 16'h0) begin errors++; $display("FAIL reset_right_in: got %h want 0000", right_in); end
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_clocks();
    int bad_m = 0, bad_s = 0, bad_l = 0, bad_r = 0, bad_v = 0;
    logic [9:0] kv;
    for (int k = 0; k < 2048; k++) begin
      kv = 10'(k);
      if (MCLK !== kv[1])  bad_m++;
      if (SCLK !== kv[3])  bad_s++;
      if (LRCLK !== kv[9]) bad_l++;
      if (RST_n !== ((k >= 1024) ? 1'b1 : 1'b0)) bad_r++;
      if (VALID !== 1'b0)  bad_v++;
      @(negedge clk);
    end
    checks++; if (bad_m !== 0) begin errors++; $display("FAIL mclk_pattern: %0d bad cycles, want 0", bad_m); end
    checks++; if (bad_s !== 0) begin errors++; $display("FAIL sclk_pattern: %0d bad cycles, want 0", bad_s); end
    checks++; if (bad_l !== 0) begin errors++; $display("FAIL lrclk_pattern: %0d bad cycles, want 0", bad_l); end
    checks++; if (bad_r !== 0) begin errors++; $display("FAIL rst_n_sequence: %0d bad cycles, want 0", bad_r); end
    checks++; if (bad_v !== 0) begin errors++; $display("FAIL valid_early: %0d pulses before warm-up, want 0", bad_v); end
  endtask

  task automatic test_rx();
    int waited = 0;
    while (VALID !== 1'b1 && waited < 2048) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (VALID !== 1'b1) begin errors++; $display("FAIL first_valid_timeout: VALID=%b want 1", VALID); end
    checks++; if (tb_cyc !== 2559) begin errors++; $display("FAIL first_valid_cycle: got %0d want 2559", tb_cyc); end
    checks++; if (left_in !== 16'h1234)  begin errors++; $display("FAIL rx_left: got %h want 1234", left_in); end
    checks++; if (right_in !== 16'hBEEF) begin errors++; $display("FAIL rx_right: got %h want beef", right_in); end
  endtask

  task automatic test_tx();
    int n0, r0, u0;
    n0 = lft_n; r0 = rht_n; u0 = unused_ones;
    repeat (1024) @(negedge clk);
    checks++; if (VALID !== 1'b1)        begin errors++; $display("FAIL tx_valid_period: VALID=%b want 1", VALID); end
    checks++; if (aout_lft !== 16'h8001) begin errors++; $display("FAIL tx_left: got %h want 8001", aout_lft); end
    checks++; if (aout_rht !== 16'h7FFE) begin errors++; $display("FAIL tx_right: got %h want 7ffe", aout_rht); end
    checks++; if ((lft_n - n0) !== 1 || (rht_n - r0) !== 1) begin
      errors++; $display("FAIL tx_decode_count: got %0d/%0d want 1/1", lft_n - n0, rht_n - r0);
    end
    checks++; if ((unused_ones - u0) !== 0) begin errors++; $display("FAIL tx_unused_bits: got %0d ones want 0", unused_ones - u0); end
  endtask

  task automatic test_back_to_back();
    adc_l     = 16'h8000;
    adc_r     = 16'h0001;
    left_out  = 16'hA5C3;
    right_out = 16'h0F0F;
    @(negedge clk);
    left_out  = 16'hFFFF;
    right_out = 16'hFFFF;
    repeat (1023) @(negedge clk);
    checks++; if (left_in !== 16'h8000)  begin errors++; $display("FAIL b2b_rx_left: got %h want 8000", left_in); end
    checks++; if (right_in !== 16'h0001) begin errors++; $display("FAIL b2b_rx_right: got %h want 0001", right_in); end
    checks++; if (aout_lft !== 16'hA5C3) begin errors++; $display("FAIL b2b_tx_left: got %h want a5c3", aout_lft); end
    checks++; if (aout_rht !== 16'h0F0F) begin errors++; $display("FAIL b2b_tx_right: got %h want 0f0f", aout_rht); end
  endtask

  task automatic test_valid();
    int pulses = 0, bad_gap = 0, last;
    last = tb_cyc;
    for (int i = 0; i < 10240; i++) begin
      @(negedge clk);
      if (VALID === 1'b1) begin
        pulses++;
        if (tb_cyc - last != 1024) bad_gap++;
        last = tb_cyc;
      end
    end
    checks++; if (pulses !== 10) begin errors++; $display("FAIL valid_count: got %0d want 10", pulses); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL valid_spacing: %0d bad gaps want 0", bad_gap); end
  endtask

  task automatic test_mid_reset();
    int waited = 0, bad_r = 0;
    while (tb_cyc[9:0] !== 10'h25A && waited < 1100) begin
      @(negedge clk);
      waited++;
    end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (MCLK !== 1'b0 || SCLK !== 1'b0 || LRCLK !== 1'b0) begin
      errors++; $display("FAIL mid_reset_clocks: got %b%b%b want 000", MCLK, SCLK, LRCLK);
    end
    checks++; if (RST_n !== 1'b0)     begin errors++; $display("FAIL mid_reset_rst_n: got %b want 0", RST_n); end
    checks++; if (SD_in !== 1'b0)     begin errors++; $display("FAIL mid_reset_sd_in: got %b want 0", SD_in); end
    checks++; if (VALID !== 1'b0)     begin errors++; $display("FAIL mid_reset_valid: got %b want 0", VALID); end
    checks++; if (left_in !== 16'h0)  begin errors++; $display("FAIL mid_reset_left_in: got %h want 0000", left_in); end
    checks++; if (right_in !== 16'h0) begin errors++; $display("FAIL mid_reset_right_in: got %h want 0000", right_in); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k <= 1024; k++) begin
      if (RST_n !== ((k >= 1024) ? 1'b1 : 1'b0)) bad_r++;
      if (k < 1024) @(negedge clk);
    end
    checks++; if (bad_r !== 0) begin errors++; $display("FAIL mid_reset_rst_n_seq: %0d bad cycles want 0", bad_r); end
    waited = 0;
    while (VALID !== 1'b1 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (tb_cyc !== 2559) begin errors++; $display("FAIL mid_reset_first_valid: got cycle %0d want 2559", tb_cyc); end
  endtask

`ifdef CODEC_IF_LOOPBACK_EN
  task automatic test_loopback();
    adc_l     = 16'h00FF;
    adc_r     = 16'h00FF;
    left_out  = 16'h0000;
    right_out = 16'h0000;
    repeat (3072) @(negedge clk);
    checks++; if (aout_lft !== 16'h00FF) begin errors++; $display("FAIL loopback_left: got %h want 00ff", aout_lft); end
    checks++; if (aout_rht !== 16'h00FF) begin errors++; $display("FAIL loopback_right: got %h want 00ff", aout_rht); end
  endtask
`endif

  initial begin
    test_reset();
    test_clocks();
    test_rx();
    test_tx();
    test_back_to_back();
    test_valid();
    test_mid_reset();
`ifdef CODEC_IF_LOOPBACK_EN
    test_loopback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codec_i2s_if.md
# codec_i2s_if

Serial audio bridge between the digital effects core and the CS4272 stereo codec. The block derives the codec master, bit and frame clocks from the system clock and deserialises the codec's ADC stream into parallel `left_in`/`right_in` words. It also serialises the effect core's `left_out`/`right_out` words into the codec's DAC stream. `VALID` is the once-per-frame sample strobe that paces the effect core.

## Interface
- DATA_W, 16: audio word width (1..24); MSB-aligned in each slot.
- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted when 1, despite the name).
- SD_out  in  1  serial ADC data from the codec.
- left_out  in  DATA_W  left DAC sample, two's complement.
- right_out  in  DATA_W  right DAC sample.
- MCLK  out  1  codec master clock, clk/4.
- SCLK  out  1  serial bit clock, clk/16.
- LRCLK  out  1  frame clock, clk/1024; high = left slot.
- RST_n  out  1  codec reset, active low.
- SD_in  out  1  serial DAC data to the codec.
- left_in  out  DATA_W  latest left ADC sample.
- right_in  out  DATA_W  latest right ADC sample.
- VALID  out  1  one-clk strobe: new inputs are on `left_in`/`right_in`, and `left_out`/`right_out` are sampled.

## Operation
- A free-running 10-bit counter `cnt` increments every clk and wraps 0x3FF→0x000.
- Clock outputs: `MCLK`=`cnt[1]`, `SCLK`=`cnt[3]`, `LRCLK`=`cnt[9]`, all registered.
- Bit position within a half-frame: `cnt[8:4]` gives 32 SCLK periods per slot.
- Strobes:
  - rise = (`cnt[3:0]`==4'b0111)
  - fall = (`cnt[3:0]`==4'b1111)
- Format is left-justified and MSB first. The first SCLK rise after an LRCLK edge carries the MSB.
- Receive path:
  - On each rise with `cnt[8:4]` < DATA_W, shift `SD_out` into the rx shift register.
  - After bit DATA_W-1, copy the register into a left holding register (LRCLK=1) or a right holding register (LRCLK=0).
  - The remaining slot bits are ignored.
- Transmit path:
  - At `cnt`==0x1FF, load `left_out` into the tx shift register and buffer `right_out`.
  - At `cnt`==0x3FF, load the buffered right word.
  - `SD_in` = tx MSB. On each fall the register shifts left, filling with 0, so bits after DATA_W transmit as 0.
- `VALID` is high for exactly the cycle in which `cnt`==0x1FF (end of the right slot).
  - In that cycle `left_in`/`right_in` already show the holding registers; they update only at that point.
  - `VALID` is suppressed until one full frame has elapsed after `RST_n` rises.
- `RST_n` stays low from reset until the first `cnt` wrap at 0x3FF→0x000, then stays high.

## Timing
- Reset values: `cnt`=0, `MCLK`/`SCLK`/`LRCLK`=0, `RST_n`=0, `SD_in`=0, `VALID`=0, `left_in`/`right_in`=0, all shift and holding registers 0.
- Reset asserted mid-frame clears everything immediately (asynchronous). After release, the codec reset sequence restarts.
- Latency from the last ADC bit to `left_in`: at most one frame (1024 clk). From `left_out` sampling to its MSB on `SD_in`: 1 clk.
- Period of `VALID`: exactly 1024 clk.
- `left_out`/`right_out` may change at any time; only the values present on the `VALID` cycle are transmitted.

## Configuration
- `CODEC_IF_LOOPBACK_EN` defined: the tx loads use the rx holding registers instead of `left_out`/`right_out`, giving ADC→DAC digital loopback. All other behaviour is unchanged.
- Macro undefined: normal operation as above.

## Structure
- Package `codec_if_pkg`: `CNT_W`=10, slot length 32, the terminal counts 0x1FF and 0x3FF, and the strobe nibble constants 4'b0111 and 4'b1111.
- Sub-module `codec_if_clkgen`: holds the counter and the `MCLK`/`SCLK`/`LRCLK` outputs, plus the rise/fall/frame strobes. The top level holds the rx/tx datapath and the reset sequencer.

## Test plan
- Reset for 10 clk, then release.
  - Expect `RST_n`=0 until clk 1024, then 1.
  - Expect `MCLK` period 4, `SCLK` period 16, `LRCLK` period 1024, with `LRCLK` high for cycles 512–1023.
- Bit-accurate codec model drives left 0x1234 and right 0xBEEF. After warm-up, the `VALID` cycle shows `left_in`=0x1234 and `right_in`=0xBEEF.
- `left_out`=0x8001 and `right_out`=0x7FFE held. The model decodes `aout_lft`=0x8001 and `aout_rht`=0x7FFE, and the unused slot bits are 0.
- Count `VALID` over 10 frames: exactly 10 single-cycle pulses, spaced 1024 clk apart, none before `RST_n` high plus one frame.
- Assert reset at `cnt`≈0x250 mid-left-slot. All outputs drop to their reset values within the same cycle, and the `RST_n` sequence repeats.
- With `CODEC_IF_LOOPBACK_EN`: ADC input 0x00FF is seen on the DAC as 0x00FF one frame later.
